// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: micro-op codes, the NZCV flags layout, arbiter FSM states
// and the rule deciding which micro-ops are allowed to commit architectural flags.
package alu_arbiter_pkg;

    localparam logic [4:0] UOP_NOP = 5'h00;
    localparam logic [4:0] UOP_ADD = 5'h01;
    localparam logic [4:0] UOP_SUB = 5'h02;
    localparam logic [4:0] UOP_AND = 5'h03;
    localparam logic [4:0] UOP_EOR = 5'h04;
    localparam logic [4:0] UOP_CMP = 5'h05;
    localparam logic [4:0] UOP_LSL = 5'h06;
    localparam logic [4:0] UOP_LSR = 5'h07;
    localparam logic [4:0] UOP_MOV = 5'h08;
    localparam logic [4:0] UOP_STR = 5'h09;
    localparam logic [4:0] UOP_LDR = 5'h0A;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } Flags;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } AluArbState;

    function automatic logic is_flag_setting(input logic [4:0] uop);
        case (uop)
            UOP_ADD, UOP_SUB, UOP_AND, UOP_EOR,
            UOP_CMP, UOP_LSL, UOP_LSR, UOP_MOV: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Codes are dense from NOP up to LDR; anything above is undefined.
    function automatic logic is_legal_uop(input logic [4:0] uop);
        return uop <= UOP_LDR;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requesting index after last_grant,
// wrapping modulo N, is returned as a one-hot grant.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [N-1:0]    grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters, one op at a time,
// and owns the architectural NZCV register.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_lhs,
    input  logic [NUM_REQ*32-1:0] req_rhs,
    input  logic [NUM_REQ*5-1:0] req_uop,
    input  logic [NUM_REQ-1:0]   req_set_flags,
    output logic [31:0]          alu_lhs,
    output logic [31:0]          alu_rhs,
    output logic [4:0]           alu_uop,
    input  logic [31:0]          alu_result,
    input  logic [3:0]           alu_flags,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [31:0]          rsp_result,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_illegal,
    output logic [3:0]           flags_q,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    // Handshakes: a request transfers on the edge where req_valid[i] & req_ready[i];
    // a response transfers on the edge where rsp_valid[i] & rsp_ready[i]. Valid may
    // not depend on ready; requesters hold payload stable while valid && !ready.

    AluArbState        state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   grant_id;
    logic [NUM_REQ-1:0] grant;
    logic [31:0]       lhs_q;
    logic [31:0]       rhs_q;
    logic [4:0]        uop_q;
    logic              set_flags_q;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_id = ID_W'(i);
        end
    end

    assign req_ready = (state == IDLE) ? (grant & req_valid) : '0;
    assign rsp_valid = (state == RESP) ? (NUM_REQ'(1) << id_q) : '0;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // The ALU only sees real operands during the single execute cycle.
    assign alu_lhs = (state == EXEC) ? lhs_q : '0;
    assign alu_rhs = (state == EXEC) ? rhs_q : '0;
    assign alu_uop = (state == EXEC) ? uop_q : UOP_NOP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            lhs_q       <= '0;
            rhs_q       <= '0;
            uop_q       <= UOP_NOP;
            set_flags_q <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_illegal <= 1'b0;
            flags_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        lhs_q       <= req_lhs[32*grant_id +: 32];
                        rhs_q       <= req_rhs[32*grant_id +: 32];
                        uop_q       <= req_uop[5*grant_id +: 5];
                        set_flags_q <= req_set_flags[grant_id];
                        id_q        <= grant_id;
                        last_grant  <= grant_id;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result  <= alu_result;
                    rsp_flags   <= alu_flags;
                    rsp_illegal <= !is_legal_uop(uop_q);
                    if (set_flags_q && is_flag_setting(uop_q)) flags_q <= alu_flags;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready[id_q]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: environment ALU, directed scenarios, randomized traffic,
// and a queue-based scoreboard fed from a behavioural model of the arbiter.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N = 2;
  localparam int W = 43;  // {id[2], illegal, rsp_flags[4], flags_q[4], result[32]}

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_set_flags, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_lhs, req_rhs;
  logic [N*5-1:0]  req_uop;
  logic [31:0]     alu_lhs, alu_rhs, alu_result, rsp_result;
  logic [4:0]      alu_uop;
  logic [3:0]      alu_flags, rsp_flags, flags_q;
  logic            rsp_illegal, busy;
  logic [1:0]      state_dbg;

  logic        v_a[N];
  logic [31:0] lhs_a[N];
  logic [31:0] rhs_a[N];
  logic [4:0]  uop_a[N];
  logic        sf_a[N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  int           grant_log[$];
  int           grant_cyc[$];
  logic         in_flight = 1'b0;
  logic         rsp_seen = 1'b0;
  int           acc_cyc = 0;
  int           model_last = N - 1;
  logic [3:0]   model_flags = 4'b0000;
  logic [31:0]  cur_lhs, cur_rhs;
  logic [4:0]   cur_uop;
  logic         rand_on = 1'b0;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_lhs(req_lhs), .req_rhs(req_rhs), .req_uop(req_uop), .req_set_flags(req_set_flags),
    .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_uop(alu_uop),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal),
    .flags_q(flags_q), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- environment ALU and reference arithmetic ----------------
  function automatic logic [35:0] alu_ref(input logic [4:0] uop, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    Flags f;
    f = '0;
    r = '0;
    s = '0;
    case (uop)
      UOP_ADD, UOP_STR, UOP_LDR: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        f.c = s[32];
        f.v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      UOP_SUB, UOP_CMP: begin
        r = a - b;
        f.c = (a >= b);
        f.v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      UOP_AND: r = a & b;
      UOP_EOR: r = a ^ b;
      UOP_LSL: r = a << b[4:0];
      UOP_LSR: r = a >> b[4:0];
      UOP_MOV: r = b;
      default: r = '0;
    endcase
    f.n = r[31];
    f.z = (r == 32'h0);
    return {f, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_ref(alu_uop, alu_lhs, alu_rhs);

  always_comb begin
    req_valid = '0;
    req_set_flags = '0;
    req_lhs = '0;
    req_rhs = '0;
    req_uop = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v_a[i];
      req_set_flags[i] = sf_a[i];
      req_lhs[i*32 +: 32] = lhs_a[i];
      req_rhs[i*32 +: 32] = rhs_a[i];
      req_uop[i*5 +: 5] = uop_a[i];
    end
  end

  // ---------------- model helpers ----------------
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic writes_flags(input logic [4:0] u);
    return u inside {UOP_ADD, UOP_SUB, UOP_AND, UOP_EOR, UOP_CMP, UOP_LSL, UOP_LSR, UOP_MOV};
  endfunction

  function automatic logic legal(input logic [4:0] u);
    return u inside {UOP_NOP, UOP_ADD, UOP_SUB, UOP_AND, UOP_EOR, UOP_CMP, UOP_LSL,
                     UOP_LSR, UOP_MOV, UOP_STR, UOP_LDR};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_flight = 1'b0;
      rsp_seen = 1'b0;
      model_last = N - 1;
      model_flags = 4'b0000;
    end else begin
      int pick;
      logic [N-1:0] exp_ready;
      pick = rr_pick(req_valid, model_last);
      exp_ready = (in_flight || pick < 0) ? '0 : (N'(1) << pick);
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("busy", 64'(busy), 64'(in_flight));

      if (in_flight && cyc == acc_cyc + 1) begin
        check("alu_uop_exec", 64'(alu_uop), 64'(cur_uop));
        check("alu_lhs_exec", 64'(alu_lhs), 64'(cur_lhs));
        check("alu_rhs_exec", 64'(alu_rhs), 64'(cur_rhs));
      end else begin
        check("alu_uop_idle", 64'(alu_uop), 64'(UOP_NOP));
        check("alu_lhs_idle", 64'(alu_lhs), 64'h0);
      end

      if (!in_flight && pick >= 0 && req_ready[pick]) begin
        logic [35:0] fr;
        logic [3:0]  fq;
        logic [1:0]  id2;
        fr = alu_ref(uop_a[pick], lhs_a[pick], rhs_a[pick]);
        fq = (sf_a[pick] && writes_flags(uop_a[pick])) ? fr[35:32] : model_flags;
        id2 = 2'(pick);
        exp_q.push_back({id2, !legal(uop_a[pick]), fr[35:32], fq, fr[31:0]});
        cur_lhs = lhs_a[pick];
        cur_rhs = rhs_a[pick];
        cur_uop = uop_a[pick];
        model_last = pick;
        acc_cyc = cyc;
        in_flight = 1'b1;
        grant_log.push_back(pick);
        grant_cyc.push_back(cyc);
      end else if (|rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'h0);
        end else begin
          logic [W-1:0] e;
          e = exp_q[0];
          check("rsp_valid", 64'(rsp_valid), 64'(N'(1) << e[42:41]));
          check("rsp_result", 64'(rsp_result), 64'(e[31:0]));
          check("rsp_flags", 64'(rsp_flags), 64'(e[39:36]));
          check("rsp_illegal", 64'(rsp_illegal), 64'(e[40]));
          check("flags_q", 64'(flags_q), 64'(e[35:32]));
          if (!rsp_seen) check("rsp_latency", 64'(cyc - acc_cyc), 64'd2);
          rsp_seen = 1'b1;
          if (rsp_ready[e[42:41]]) begin
            void'(exp_q.pop_front());
            model_flags = e[35:32];
            in_flight = 1'b0;
            rsp_seen = 1'b0;
          end
        end
      end else if (in_flight && cyc >= acc_cyc + 2) begin
        check("rsp_missing", 64'(rsp_valid), 64'(N'(1) << model_last));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int i, input logic [4:0] u, input logic [31:0] a,
                       input logic [31:0] b, input logic sf);
    int t;
    v_a[i] = 1'b1;
    uop_a[i] = u;
    lhs_a[i] = a;
    rhs_a[i] = b;
    sf_a[i] = sf;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[i] && t < 200);
    if (!req_ready[i]) check("issue_timeout", 64'(req_ready), 64'(N'(1) << i));
    @(posedge clk);
    #1;
    v_a[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, input logic [31:0] er, input logic [3:0] ef,
                          input logic [3:0] efq, input logic eill);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid[i] && t < 50);
    check("dir_rsp_valid", 64'(rsp_valid), 64'(N'(1) << i));
    check("dir_latency", 64'(t), 64'd2);
    check("dir_result", 64'(rsp_result), 64'(er));
    check("dir_flags", 64'(rsp_flags), 64'(ef));
    check("dir_flags_q", 64'(flags_q), 64'(efq));
    check("dir_illegal", 64'(rsp_illegal), 64'(eill));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_driver(input int i, input int n_ops);
    for (int k = 0; k < n_ops; k++) begin
      int t;
      int gap;
      logic done;
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      v_a[i] = 1'b1;
      uop_a[i] = ($urandom_range(0, 11) == 11) ? 5'h1F : 5'($urandom_range(0, 10));
      lhs_a[i] = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
      rhs_a[i] = ($urandom_range(0, 3) == 0) ? lhs_a[i] : $urandom;
      sf_a[i] = 1'($urandom_range(0, 1));
      t = 0;
      done = 1'b0;
      while (!done && t < 300) begin
        @(negedge clk);
        t++;
        if (req_ready[i]) done = 1'b1;
        else if ($urandom_range(0, 15) == 0) t = 1000;  // withdraw before grant
      end
      if (!done && t < 1000) check("rand_timeout", 64'(req_ready), 64'(N'(1) << i));
      @(posedge clk);
      #1;
      v_a[i] = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      v_a[i] = 1'b0;
      lhs_a[i] = '0;
      rhs_a[i] = '0;
      uop_a[i] = UOP_NOP;
      sf_a[i] = 1'b0;
    end
    rsp_ready = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_flags_q", 64'(flags_q), 64'h0);
    check("rst_alu_uop", 64'(alu_uop), 64'(UOP_NOP));
    check("rst_rsp_result", 64'(rsp_result), 64'h0);
    check("rst_state", 64'(state_dbg), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = '1;

    // Both requesters continuously valid: strict alternation starting at 0.
    grant_log.delete();
    grant_cyc.delete();
    fork
      begin
        issue(0, UOP_ADD, 32'd1, 32'd2, 1'b0);
        issue(0, UOP_SUB, 32'd9, 32'd3, 1'b0);
      end
      begin
        issue(1, UOP_EOR, 32'hFF, 32'h0F, 1'b0);
        issue(1, UOP_LSL, 32'h1, 32'd4, 1'b0);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("rr_count", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4) begin
      for (int k = 0; k < 4; k++) check("rr_order", 64'(grant_log[k]), 64'(k % 2));
      for (int k = 0; k < 3; k++) check("rr_spacing", 64'(grant_cyc[k+1] - grant_cyc[k]), 64'd3);
    end

    // Signed overflow into the sign bit, flags committed.
    issue(0, UOP_ADD, 32'h7FFFFFFF, 32'h1, 1'b1);
    wait_rsp(0, 32'h80000000, 4'b1001, 4'b1001, 1'b0);
    // Zero result without commit.
    issue(0, UOP_SUB, 32'd5, 32'd5, 1'b0);
    wait_rsp(0, 32'h0, 4'b0110, 4'b1001, 1'b0);
    // Address op never commits; undefined code flagged illegal.
    issue(1, UOP_LDR, 32'h100, 32'h8, 1'b1);
    wait_rsp(1, 32'h108, 4'b0000, 4'b1001, 1'b0);
    issue(0, 5'h1F, 32'h3, 32'h4, 1'b1);
    wait_rsp(0, 32'h0, 4'b0100, 4'b1001, 1'b1);

    // Back-pressured response blocks the other requester.
    rsp_ready = '0;
    issue(0, UOP_MOV, 32'h0, 32'h55, 1'b1);
    v_a[1] = 1'b1;
    uop_a[1] = UOP_AND;
    lhs_a[1] = 32'hF0F0;
    rhs_a[1] = 32'hFF00;
    sf_a[1] = 1'b0;
    @(negedge clk);
    repeat (4) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'h1);
      check("hold_rsp_result", 64'(rsp_result), 64'h55);
      check("hold_req_ready", 64'(req_ready), 64'h0);
    end
    @(posedge clk);
    #1;
    rsp_ready = '1;
    @(negedge clk);
    @(negedge clk);
    check("after_consume_grant", 64'(req_ready), 64'h2);
    @(posedge clk);
    #1;
    v_a[1] = 1'b0;
    wait_rsp(1, 32'hF000, 4'b0000, 4'b0000, 1'b0);

    // Reset during EXEC drops the op.
    issue(0, UOP_ADD, 32'd10, 32'd20, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_alu_uop", 64'(alu_uop), 64'(UOP_NOP));
    check("arst_alu_lhs", 64'(alu_lhs), 64'h0);
    check("arst_rsp_result", 64'(rsp_result), 64'h0);
    check("arst_flags_q", 64'(flags_q), 64'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_no_rsp", 64'(rsp_valid), 64'h0);
    @(posedge clk);
    #1;
    issue(1, UOP_SUB, 32'd3, 32'd4, 1'b1);
    wait_rsp(1, 32'hFFFFFFFF, 4'b1000, 4'b1000, 1'b0);

    // Randomized traffic with random response back-pressure.
    rand_on = 1'b1;
    fork
      begin
        fork
          rand_driver(0, 40);
          rand_driver(1, 40);
        join
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          rsp_ready = N'($urandom_range(0, 3));
        end
      end
    join
    rsp_ready = '1;
    for (int t = 0; t < 50 && (exp_q.size() != 0 || in_flight); t++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
